// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO push arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_BURST_MAX  = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side requests and FIFO write port shared by the arbiter and its environment.
interface fifo_push_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    localparam int unsigned OWNER_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            ack;
    logic                          full;
    logic                          push;
    logic [DATA_WIDTH-1:0]         dataIn;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;

    modport master (
        input  req,
        input  reqData,
        input  full,
        output ack,
        output push,
        output dataIn,
        output owner,
        output busy
    );

    modport slave (
        output req,
        output reqData,
        output full,
        input  ack,
        input  push,
        input  dataIn,
        input  owner,
        input  busy
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;

    // Modular add that also works when NUM_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        int unsigned s;
        s = 32'(a) + 32'(b);
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    always_comb begin
        w_rot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_rot[j] = i_req[wrap_add(IDX_W'(j), i_ptr)];
        end
    end

    // Lowest set bit of the rotated vector is the winner relative to i_ptr.
    always_comb begin
        w_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_W'(j);
            end
        end
    end

    assign o_found = |i_req;
    assign o_index = wrap_add(w_off, i_ptr);

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded bursts.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BURST_MAX  = DEF_BURST_MAX
) (
    input  logic               clock,
    input  logic               reset,
    fifo_push_arbiter_if.master bus
);

    localparam int unsigned OWNER_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W   = $clog2(BURST_MAX + 1);

    arb_state_t          r_state;
    logic [OWNER_W-1:0]  r_rr_ptr;
    logic [OWNER_W-1:0]  r_owner;
    logic [CNT_W-1:0]    r_burst_cnt;

    arb_state_t          w_state_nxt;
    logic [OWNER_W-1:0]  w_rr_ptr_nxt;
    logic [OWNER_W-1:0]  w_owner_nxt;
    logic [CNT_W-1:0]    w_burst_cnt_nxt;

    logic                w_found;
    logic [OWNER_W-1:0]  w_pick;
    logic                w_owner_req;
    logic [OWNER_W-1:0]  w_after_owner;
    logic                w_push;
    logic [NUM_REQ-1:0]  w_ack;
    logic [DATA_WIDTH-1:0] w_data;
    logic                w_busy;

    logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign w_words[g] = bus.reqData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_index (w_pick)
    );

    assign w_owner_req   = bus.req[r_owner];
    assign w_after_owner = (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + OWNER_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Next-state and write-port outputs; outputs follow inputs within the cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_push          = 1'b0;
        w_ack           = '0;
        w_data          = '0;
        w_busy          = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ARB_BURST;
                    w_owner_nxt     = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end

            ARB_BURST: begin
                w_busy = 1'b1;
                w_data = w_words[r_owner];
                w_push = w_owner_req & ~bus.full;
                if (w_push) begin
                    w_ack[r_owner] = 1'b1;
                end

                // A dropped request or a finished burst both hand priority to the next index.
                if (!w_owner_req || (w_push && r_burst_cnt == CNT_W'(BURST_MAX - 1))) begin
                    w_state_nxt     = ARB_IDLE;
                    w_rr_ptr_nxt    = w_after_owner;
                    w_burst_cnt_nxt = '0;
                end else if (w_push) begin
                    w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign bus.push   = w_push;
    assign bus.ack    = w_ack;
    assign bus.dataIn = w_data;
    assign bus.busy   = w_busy;
    assign bus.owner  = r_owner;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter (BURST_MAX=4 main instance, BURST_MAX=1 side instance).
module tb_fifo_push_arbiter;

    logic       clock;
    logic       reset;
    logic [7:0] d [4];
    int         n_checks;
    int         n_errors;
    int         n_push;

    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus  ();
    fifo_push_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus1 ();

    assign bus.reqData  = {d[3], d[2], d[1], d[0]};
    assign bus1.req     = bus.req;
    assign bus1.reqData = bus.reqData;
    assign bus1.full    = bus.full;

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(1)) u_dut_b1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic exp(input string tag, input logic p, input logic [3:0] a,
                       input logic [7:0] dv, input logic [1:0] o, input logic b);
        #1;
        check({tag, ".push"},   32'(bus.push),   32'(p));
        check({tag, ".ack"},    32'(bus.ack),    32'(a));
        check({tag, ".dataIn"}, 32'(bus.dataIn), 32'(dv));
        check({tag, ".owner"},  32'(bus.owner),  32'(o));
        check({tag, ".busy"},   32'(bus.busy),   32'(b));
    endtask

    task automatic exp1(input string tag, input logic p, input logic [1:0] o, input logic b);
        #1;
        check({tag, ".push"},  32'(bus1.push),  32'(p));
        check({tag, ".owner"}, 32'(bus1.owner), 32'(o));
        check({tag, ".busy"},  32'(bus1.busy),  32'(b));
    endtask

    initial begin
        logic [1:0] o;
        logic [3:0] oh;
        n_checks = 0;
        n_errors = 0;
        n_push   = 0;
        reset    = 1'b0;
        bus.req  = 4'b1111;
        bus.full = 1'b0;
        d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2; d[3] = 8'hD3;

        // Reset hold with every producer requesting.
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp("rst_hold", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        end
        exp1("rst_hold_b1", 1'b0, 2'd0, 1'b0);
        cyc();
        reset = 1'b1;
        exp("rst_rel", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        cyc();
        exp("first_grant", 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1);
        cyc();
        bus.req = 4'b0000;
        exp("drop0", 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1);
        cyc();
        exp("idle0", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);

        // Single producer 2, three words then drop.
        bus.req = 4'b0100;
        d[2] = 8'h22;
        exp("sp_arb", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        cyc();
        exp("sp_w0", 1'b1, 4'b0100, 8'h22, 2'd2, 1'b1);
        cyc();
        d[2] = 8'h23;
        exp("sp_w1", 1'b1, 4'b0100, 8'h23, 2'd2, 1'b1);
        cyc();
        d[2] = 8'h24;
        exp("sp_w2", 1'b1, 4'b0100, 8'h24, 2'd2, 1'b1);
        cyc();
        bus.req = 4'b0000;
        exp("sp_drop", 1'b0, 4'b0000, 8'h24, 2'd2, 1'b1);
        cyc();
        exp("sp_idle", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);

        // All requesting: scan resumes at 3, then 0,1,2 with 4 words and 1 idle cycle each.
        bus.req = 4'b1111;
        exp("rr_arb", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
        cyc();
        for (int g = 0; g < 4; g++) begin
            o  = 2'(3 + g);
            oh = 4'b0001 << o;
            for (int k = 0; k < 4; k++) begin
                exp("rr_push", 1'b1, oh, d[o], o, 1'b1);
                if (bus.push) n_push++;
                cyc();
            end
            exp("rr_idle", 1'b0, 4'b0000, 8'h00, o, 1'b0);
            if (bus.push) n_push++;
            cyc();
        end
        check("rr_push_count", 32'(n_push), 32'd16);
        exp("rr_regrant3", 1'b1, 4'b1000, d[3], 2'd3, 1'b1);

        // Steer the grant to producer 1, then stall it on full mid-burst.
        bus.req = 4'b0010;
        exp("fs_rel3", 1'b0, 4'b0000, d[3], 2'd3, 1'b1);
        cyc();
        exp("fs_idle", 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
        cyc();
        exp("fs_w0", 1'b1, 4'b0010, d[1], 2'd1, 1'b1);
        cyc();
        exp("fs_w1", 1'b1, 4'b0010, d[1], 2'd1, 1'b1);
        cyc();
        bus.full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp("fs_stall", 1'b0, 4'b0000, d[1], 2'd1, 1'b1);
            cyc();
        end
        bus.full = 1'b0;
        exp("fs_w2", 1'b1, 4'b0010, d[1], 2'd1, 1'b1);
        cyc();
        exp("fs_w3", 1'b1, 4'b0010, d[1], 2'd1, 1'b1);
        cyc();
        bus.req = 4'b1111;
        exp("fs_idle2", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0);
        cyc();
        exp("fs_next2", 1'b1, 4'b0100, d[2], 2'd2, 1'b1);

        // Producer 3 stalled on full, then drops its request in the same cycle as full.
        bus.req = 4'b1001;
        exp("ds_rel2", 1'b0, 4'b0000, d[2], 2'd2, 1'b1);
        cyc();
        exp("ds_idle", 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
        cyc();
        bus.full = 1'b1;
        exp("ds_stall", 1'b0, 4'b0000, d[3], 2'd3, 1'b1);
        cyc();
        exp("ds_stall2", 1'b0, 4'b0000, d[3], 2'd3, 1'b1);
        bus.req = 4'b0001;
        exp("ds_drop", 1'b0, 4'b0000, d[3], 2'd3, 1'b1);
        cyc();
        bus.full = 1'b0;
        exp("ds_idle2", 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
        cyc();
        exp("ds_next0", 1'b1, 4'b0001, d[0], 2'd0, 1'b1);

        // Reset asserted asynchronously during producer 2's burst.
        bus.req = 4'b0100;
        exp("rm_rel0", 1'b0, 4'b0000, d[0], 2'd0, 1'b1);
        cyc();
        exp("rm_idle", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        cyc();
        exp("rm_w0", 1'b1, 4'b0100, d[2], 2'd2, 1'b1);
        cyc();
        exp("rm_w1", 1'b1, 4'b0100, d[2], 2'd2, 1'b1);
        cyc();
        exp("rm_w2", 1'b1, 4'b0100, d[2], 2'd2, 1'b1);
        reset = 1'b0;
        exp("rm_async", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        exp1("rm_async_b1", 1'b0, 2'd0, 1'b0);
        cyc();
        cyc();
        bus.req = 4'b0110;
        reset = 1'b1;
        exp("rm_rel", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
        cyc();
        exp("rm_grant1", 1'b1, 4'b0010, d[1], 2'd1, 1'b1);

        // Single-word bursts alternate between producers 1 and 2 with an idle cycle each.
        exp1("b1_w1", 1'b1, 2'd1, 1'b1);
        cyc();
        exp1("b1_idle1", 1'b0, 2'd1, 1'b0);
        cyc();
        exp1("b1_w2", 1'b1, 2'd2, 1'b1);
        cyc();
        exp1("b1_idle2", 1'b0, 2'd2, 1'b0);
        cyc();
        exp1("b1_w1b", 1'b1, 2'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
